// File: rtl/pulse_hs_pkg.sv
// ---------------------------------------------------------------------------
// pulse_hs_pkg
// Shared types and default parameter values for the pulse handshake sender
// and its ack synchronizer.
//   hs_state_t       : 4-phase handshake FSM states
//   SYNC_STAGES_DEF  : default ack synchronizer depth
//   PEND_W_DEF       : default pending-event counter width
//   TIMEOUT_CYC_DEF  : default per-phase timeout (only with PULSE_HS_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } hs_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int PEND_W_DEF      = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/pulse_handshake_tx_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a single asynchronous level. Reusable for any
// crossing into the clk50 domain.
// Ports:
//   clk50   in  : destination clock
//   reset_n in  : synchronous active-low reset, clears every stage
//   d       in  : asynchronous input level
//   q       out : d delayed by STAGES clk50 edges
// Parameters:
//   STAGES  : number of flops in the chain (>= 2)
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: reset is synchronous, so it is sampled inside the clocked block
  // rather than listed in the sensitivity list.
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// ---------------------------------------------------------------------------
// pulse_handshake_tx
// Sending end of a 4-phase req/ack crossing. Single-cycle event pulses in
// the clk50 domain are queued in a saturating counter and each one is sent
// to a slow/asynchronous consumer as a full req/ack handshake.
// Ports:
//   clk50       in  : system clock, all logic on posedge
//   reset_n     in  : synchronous active-low reset
//   pulse_in    in  : single-cycle event to transmit
//   clr_err     in  : single-cycle clear of sticky flags
//   async_ack   in  : ack from consumer domain (asynchronous)
//   req_out     out : registered request level
//   busy        out : handshake in progress (state != IDLE)
//   pending_cnt out : events queued but not yet launched
//   overflow    out : sticky, an event was dropped at a full queue
//   timeout_err out : sticky, a handshake phase was abandoned
// Configuration macro:
//   PULSE_HS_TIMEOUT_EN : enables the per-phase timeout counter. When
//   undefined the FSM waits indefinitely and timeout_err is tied 0.
// ---------------------------------------------------------------------------
module pulse_handshake_tx
  import pulse_hs_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int PEND_W      = PEND_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              pulse_in,
  input  logic              clr_err,
  input  logic              async_ack,
  output logic              req_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              overflow,
  output logic              timeout_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  hs_state_t         state_q;
  logic              req_q;
  logic              ack_s;
  logic              launch;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              ovf_set;
  logic              ovf_q;
  logic              to_set;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk50   (clk50),
    .reset_n (reset_n),
    .d       (async_ack),
    .q       (ack_s)
  );

  // A fresh pulse launches immediately when idle, without passing through
  // the queue, so an empty idle sender adds no extra latency.
  assign launch = (state_q == IDLE) && ((pend_q != '0) || pulse_in);

`ifdef PULSE_HS_TIMEOUT_EN
  localparam int PHASE_W = $clog2(TIMEOUT_CYC + 1);

  logic [PHASE_W-1:0] phase_q;
  logic               expired;
  logic               advance;

  // phase_q counts edges spent in the current phase; the phase is given up
  // on the TIMEOUT_CYC-th edge after entry.
  assign expired = (phase_q == PHASE_W'(TIMEOUT_CYC - 1));
  assign to_set  = expired && (((state_q == REQ_HI) && !ack_s) ||
                               ((state_q == ACK_LO) &&  ack_s));
  assign advance = ((state_q == REQ_HI) && ack_s) ||
                   ((state_q == ACK_LO) && !ack_s) || to_set;

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else if ((state_q == IDLE) || advance) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign to_set = 1'b0;
`endif

  // Handshake FSM; req_out is produced directly by a flop so the consumer
  // never sees a combinational glitch.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= REQ_HI;
            req_q   <= 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            state_q <= ACK_LO;
            req_q   <= 1'b0;
          end
`ifdef PULSE_HS_TIMEOUT_EN
          else if (to_set) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
`endif
        end
        ACK_LO: begin
          if (!ack_s || to_set) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Pending counter: +pulse_in -launch, saturating at PEND_MAX. A launch
  // without a pulse only happens with a non-empty queue, so no underflow.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (pulse_in && !launch) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!pulse_in && launch) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      // Set has priority over clear so a coincident drop is never lost.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef PULSE_HS_TIMEOUT_EN
  logic to_q;

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      to_q <= 1'b0;
    end else if (to_set) begin
      to_q <= 1'b1;
    end else if (clr_err) begin
      to_q <= 1'b0;
    end
  end

  assign timeout_err = to_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_out     = req_q;
  assign busy        = (state_q != IDLE);
  assign pending_cnt = pend_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// ---------------------------------------------------------------------------
// tb_pulse_handshake_tx
// Directed self-checking bench for pulse_handshake_tx with SYNC_STAGES=2,
// PEND_W=2 and TIMEOUT_CYC=16. Inputs change 1 ns after each rising edge and
// outputs are checked at the same point. Builds with or without
// PULSE_HS_TIMEOUT_EN; the timeout scenario adapts to the macro.
// ---------------------------------------------------------------------------
module tb_pulse_handshake_tx;

  logic       clk50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic       clr_err = 1'b0;
  logic       async_ack = 1'b0;
  logic       req_out;
  logic       busy;
  logic [1:0] pending_cnt;
  logic       overflow;
  logic       timeout_err;

  int n_total = 0;
  int n_pass  = 0;
  int rises   = 0;
  logic req_prev = 1'b0;

  pulse_handshake_tx #(
    .SYNC_STAGES (2),
    .PEND_W      (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk50       (clk50),
    .reset_n     (reset_n),
    .pulse_in    (pulse_in),
    .clr_err     (clr_err),
    .async_ack   (async_ack),
    .req_out     (req_out),
    .busy        (busy),
    .pending_cnt (pending_cnt),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk50 = ~clk50;

  // Count rising edges of req_out seen on the falling clock edge.
  always @(negedge clk50) begin
    if (req_out === 1'b1 && req_prev === 1'b0) rises++;
    req_prev = req_out;
  end

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    pulse_in  = 1'b0;
    clr_err   = 1'b0;
    async_ack = 1'b0;
    steps(2);
    reset_n   = 1'b1;
  endtask

  task automatic wait_req(input logic lvl, output bit ok);
    int n = 0;
    while (req_out !== lvl && n < 50) begin
      step();
      n++;
    end
    ok = (req_out === lvl);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  // Full 4-phase handshake from the consumer side; returns at the first
  // cycle the sender is back in IDLE.
  task automatic serve(output bit ok);
    bit a, b, c;
    wait_req(1'b1, a);
    async_ack = 1'b1;
    wait_req(1'b0, b);
    async_ack = 1'b0;
    wait_idle(c);
    ok = a && b && c;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({req_out, busy, pending_cnt, overflow, timeout_err} !== 6'b0)
      $display("FAIL reset_init: got %b expected 000000",
               {req_out, busy, pending_cnt, overflow, timeout_err});
    else n_pass++;
    // Reach REQ_HI with pending_cnt=3, then reset for two edges.
    pulse_in = 1'b1;
    steps(4);
    pulse_in = 1'b0;
    n_total++;
    if ({req_out, busy, pending_cnt} !== 4'b1111)
      $display("FAIL reset_setup: got %b expected 1111", {req_out, busy, pending_cnt});
    else n_pass++;
    apply_reset();
    n_total++;
    if ({req_out, busy, pending_cnt, overflow, timeout_err} !== 6'b0)
      $display("FAIL reset_mid_hs: got %b expected 000000",
               {req_out, busy, pending_cnt, overflow, timeout_err});
    else n_pass++;
  endtask

  task automatic test_single();
    pulse_in = 1'b1;
    n_total++;
    if (req_out !== 1'b0) $display("FAIL single_req_before: got %b expected 0", req_out);
    else n_pass++;
    step();
    pulse_in = 1'b0;
    n_total++;
    if ({req_out, pending_cnt} !== 3'b100)
      $display("FAIL single_req_rise: got %b expected 100", {req_out, pending_cnt});
    else n_pass++;
    steps(5);
    async_ack = 1'b1;
    steps(2);
    n_total++;
    if (req_out !== 1'b1) $display("FAIL single_req_hold_2: got %b expected 1", req_out);
    else n_pass++;
    step();
    n_total++;
    if ({req_out, busy} !== 2'b01)
      $display("FAIL single_req_fall_3: got %b expected 01", {req_out, busy});
    else n_pass++;
    steps(5);
    async_ack = 1'b0;
    steps(2);
    n_total++;
    if (busy !== 1'b1) $display("FAIL single_busy_hold_2: got %b expected 1", busy);
    else n_pass++;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL single_busy_fall_3: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_burst();
    int base;
    bit ok;
    logic [1:0] exp_pend [3] = '{2'd0, 2'd1, 2'd2};
    base = rises;
    pulse_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (pending_cnt !== exp_pend[i])
        $display("FAIL burst_pend_%0d: got %0d expected %0d", i, pending_cnt, exp_pend[i]);
      else n_pass++;
    end
    pulse_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      serve(ok);
      step();
      n_total++;
      if (!ok || req_out !== 1'b1 || pending_cnt !== 2'(1 - i))
        $display("FAIL burst_launch_%0d: ok=%0d req=%b pend=%0d expected ok=1 req=1 pend=%0d",
                 i, ok, req_out, pending_cnt, 1 - i);
      else n_pass++;
    end
    serve(ok);
    steps(10);
    n_total++;
    if (!ok || {req_out, busy, overflow} !== 3'b000 || rises - base != 3)
      $display("FAIL burst_end: ok=%0d req=%b busy=%b ovf=%b pulses=%0d expected 1 0 0 0 3",
               ok, req_out, busy, overflow, rises - base);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    pulse_in = 1'b1;
    steps(4);
    n_total++;
    if ({pending_cnt, overflow} !== 3'b110)
      $display("FAIL ovf_full: got %b expected 110", {pending_cnt, overflow});
    else n_pass++;
    steps(2);
    pulse_in = 1'b0;
    n_total++;
    if ({pending_cnt, overflow} !== 3'b111)
      $display("FAIL ovf_set: got %b expected 111", {pending_cnt, overflow});
    else n_pass++;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_total++;
    if ({pending_cnt, overflow} !== 3'b110)
      $display("FAIL ovf_clr: got %b expected 110", {pending_cnt, overflow});
    else n_pass++;
    pulse_in = 1'b1;
    clr_err  = 1'b1;
    step();
    pulse_in = 1'b0;
    clr_err  = 1'b0;
    n_total++;
    if ({pending_cnt, overflow} !== 3'b111)
      $display("FAIL ovf_set_wins: got %b expected 111", {pending_cnt, overflow});
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_timeout();
    apply_reset();
    pulse_in = 1'b1;
    step();
    step();
    pulse_in = 1'b0;
    n_total++;
    if ({req_out, pending_cnt} !== 3'b101)
      $display("FAIL to_setup: got %b expected 101", {req_out, pending_cnt});
    else n_pass++;
`ifdef PULSE_HS_TIMEOUT_EN
    steps(14);
    n_total++;
    if ({req_out, timeout_err} !== 2'b10)
      $display("FAIL to_edge15: got %b expected 10", {req_out, timeout_err});
    else n_pass++;
    step();
    n_total++;
    if ({req_out, busy, timeout_err} !== 3'b001)
      $display("FAIL to_edge16: got %b expected 001", {req_out, busy, timeout_err});
    else n_pass++;
    step();
    n_total++;
    if ({req_out, pending_cnt} !== 3'b100)
      $display("FAIL to_next_launch: got %b expected 100", {req_out, pending_cnt});
    else n_pass++;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL to_clr: got %b expected 0", timeout_err);
    else n_pass++;
`else
    steps(200);
    n_total++;
    if ({req_out, busy, timeout_err} !== 3'b110)
      $display("FAIL to_disabled: got %b expected 110", {req_out, busy, timeout_err});
    else n_pass++;
`endif
    apply_reset();
  endtask

  task automatic test_simultaneous();
    bit ok;
    pulse_in = 1'b1;
    steps(3);
    pulse_in = 1'b0;
    serve(ok);
    n_total++;
    if (!ok || busy !== 1'b0 || pending_cnt !== 2'd2)
      $display("FAIL simul_setup: ok=%0d busy=%b pend=%0d expected 1 0 2", ok, busy, pending_cnt);
    else n_pass++;
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    n_total++;
    if ({req_out, pending_cnt} !== 3'b110)
      $display("FAIL simul_launch: got %b expected 110", {req_out, pending_cnt});
    else n_pass++;
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
